csel_seq_adder: RTL and testbench

//  Multi-cycle carry-select adder sequencer. Adds two WIDTH-bit operands one CHUNK-bit slice per cycle, LSB slice first.

---
 rtl/csel_seq_adder_pkg.sv | 27 ++
 rtl/csel_seq_adder_slice.sv | 24 ++
 rtl/csel_seq_adder.sv | 117 +++++++++++
 tb/tb_csel_seq_adder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/csel_seq_adder_pkg.sv
// Shared definitions for the sequential carry-select adder: FSM encoding and
// slice-count / index-width derivation from the operand geometry.
package csel_seq_adder_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  function automatic int nchunk_f(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-slice adder still needs a 1-bit index so the port/part-select stay legal.
  function automatic int idx_w_f(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/csel_seq_adder_slice.sv
// One CHUNK-bit carry-select slice: both carry-in sums formed in parallel,
// then the registered carry picks one. Purely combinational.
module csel_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x_i,
  input  logic [CHUNK-1:0] y_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             c_o
);

  logic [CHUNK:0] s0;
  logic [CHUNK:0] s1;
  logic [CHUNK:0] sel;

  assign s0  = {1'b0, x_i} + {1'b0, y_i};
  assign s1  = {1'b0, x_i} + {1'b0, y_i} + {{CHUNK{1'b0}}, 1'b1};
  assign sel = c_i ? s1 : s0;

  assign sum_o = sel[CHUNK-1:0];
  assign c_o   = sel[CHUNK];

endmodule

// File: rtl/csel_seq_adder.sv
// Multi-cycle adder: one CHUNK-bit slice per cycle, LSB first, using a single
// carry-select slice and a registered carry between slices.
module csel_seq_adder
  import csel_seq_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state_o
);

  localparam int NCHUNK = nchunk_f(WIDTH, CHUNK);
  localparam int IDX_W  = idx_w_f(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;

  logic [CHUNK-1:0]   slice_x;
  logic [CHUNK-1:0]   slice_y;
  logic [CHUNK-1:0]   slice_sum;
  logic               slice_c;

  assign slice_x = a_q[idx_q*CHUNK +: CHUNK];
  assign slice_y = b_q[idx_q*CHUNK +: CHUNK];

  csel_slice #(.CHUNK(CHUNK)) u_slice (
    .x_i   (slice_x),
    .y_i   (slice_y),
    .c_i   (carry_q),
    .sum_o (slice_sum),
    .c_o   (slice_c)
  );

  // Handshake: a request is taken on a rising edge where start=1 and ready=1;
  // start and operands are ignored otherwise, nothing is queued, and done
  // pulses for one cycle when sum/cout become valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q[idx_q*CHUNK +: CHUNK] <= slice_sum;
          carry_q <= slice_c;
          if (idx_q == LAST_IDX) begin
            cout_q  <= slice_c;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_DONE: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready       = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_csel_seq_adder.sv
// Bench for csel_seq_adder: directed table, multi-cycle corner sequences,
// random operations against an arithmetic reference, plus a CHUNK=WIDTH instance.
module tb_csel_seq_adder;

  localparam int W  = 32;
  localparam int C  = 8;
  localparam int NC = W / C;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT with 8-bit slices
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         ready, busy, done, cout;
  logic [W-1:0] sum;
  logic [1:0]   dbg_state;

  csel_seq_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout),
    .dbg_state_o(dbg_state)
  );

  // DUT with a single full-width slice
  logic         w_start = 1'b0;
  logic [W-1:0] w_a = '0;
  logic [W-1:0] w_b = '0;
  logic         w_cin = 1'b0;
  logic         w_ready, w_busy, w_done, w_cout;
  logic [W-1:0] w_sum;
  logic [1:0]   w_dbg_state;

  csel_seq_adder #(.WIDTH(W), .CHUNK(W)) dut32 (
    .clk(clk), .rst(rst), .start(w_start), .a(w_a), .b(w_b), .cin(w_cin),
    .ready(w_ready), .busy(w_busy), .done(w_done), .sum(w_sum), .cout(w_cout),
    .dbg_state_o(w_dbg_state)
  );

  // scoreboard
  int n_chk  = 0;
  int n_pass = 0;
  logic [W:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // reference: plain (WIDTH+1)-bit addition
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  task automatic sb_compare(input string tag, input logic [W:0] act);
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_done"}, 64'(1), 64'(0));
    end else begin
      check({tag, "_result"}, 64'(act), 64'(exp_q.pop_front()));
    end
  endtask

  // driver: one operation on the 8-bit instance; poke re-pulses start mid-run
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                       input logic [W:0] exp, input bit poke, input string tag);
    int done_at;
    int n_done;
    bit rdy_bad;
    bit busy_bad;
    done_at = -1; n_done = 0; rdy_bad = 0; busy_bad = 0;
    @(negedge clk);
    check({tag, "_ready_idle"}, 64'(ready), 64'(1));
    a = xa; b = xb; cin = xc; start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom);
    for (int k = 1; k <= NC + 3; k++) begin
      @(negedge clk);
      if (poke) begin
        start = (k == 2);
        if (k == 2) begin a = ~xa; b = $urandom; cin = ~xc; end
      end
      if (k <= NC + 1 && ready !== 1'b0) rdy_bad = 1;
      if (k <= NC && busy !== 1'b1) busy_bad = 1;
      if (k == NC + 2) check({tag, "_ready_back"}, 64'(ready), 64'(1));
      if (done === 1'b1) begin
        n_done++;
        done_at = k;
        sb_compare(tag, {cout, sum});
      end
    end
    start = 1'b0;
    check({tag, "_ready_low_while_running"}, 64'(rdy_bad), 64'(0));
    check({tag, "_busy_while_running"}, 64'(busy_bad), 64'(0));
    check({tag, "_done_cycle"}, 64'(done_at), 64'(NC + 1));
    check({tag, "_done_count"}, 64'(n_done), 64'(1));
    check({tag, "_result_held"}, 64'({cout, sum}), 64'(exp));
    exp_q.delete();
  endtask

  // driver for the single-slice instance
  task automatic do_op32(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         input logic [W:0] exp, input string tag);
    int done_at;
    done_at = -1;
    @(negedge clk);
    w_a = xa; w_b = xb; w_cin = xc; w_start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    w_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (w_done === 1'b1) begin
        done_at = k;
        sb_compare(tag, {w_cout, w_sum});
      end
    end
    check({tag, "_done_cycle"}, 64'(done_at), 64'(2));
    check({tag, "_ready"}, 64'(w_ready), 64'(1));
    exp_q.delete();
  endtask

  initial begin
    int d1, d2;
    bit issued, saw_done;
    logic [W-1:0] ra, rb;
    logic rc;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
    vecs[1] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};
    vecs[6] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_result", 64'({cout, sum}), 64'(0));
    check("rst_w_ready", 64'(w_ready), 64'(1));
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum}, 1'b0,
            $sformatf("vec%0d", i));
    end

    // start pulsed with new operands while busy is ignored
    do_op(32'h1234_5678, 32'h1111_1111, 1'b1, {1'b0, 32'h2345_678A}, 1'b1, "busy_poke");

    // reset at cycle 2 aborts the operation
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h0101_0101; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_partial_slice0", 64'(sum), 64'(32'h0000_00F1));
    rst = 1'b1; #1;
    check("abort_sum", 64'(sum), 64'(0));
    check("abort_cout", 64'(cout), 64'(0));
    check("abort_ready", 64'(ready), 64'(1));
    check("abort_busy", 64'(busy), 64'(0));
    saw_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rst = 1'b0;
      if (done === 1'b1) saw_done = 1;
    end
    check("abort_no_done", 64'(saw_done), 64'(0));
    do_op(32'hDEAD_BEEF, 32'h0101_0101, 1'b1, ref_add(32'hDEAD_BEEF, 32'h0101_0101, 1'b1),
          1'b0, "after_abort");

    // back-to-back: second start in the cycle ready returns (done cycles 5 and 11)
    d1 = -1; d2 = -1; issued = 0;
    @(negedge clk);
    a = 32'h89AB_CDEF; b = 32'h7654_3210; cin = 1'b0; start = 1'b1;
    exp_q.push_back(ref_add(32'h89AB_CDEF, 32'h7654_3210, 1'b0));
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 2 * NC + 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        if (d1 < 0) d1 = k; else d2 = k;
        sb_compare("b2b", {cout, sum});
      end
      if (ready === 1'b1 && !issued) begin
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; start = 1'b1;
        exp_q.push_back(ref_add(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1));
        issued = 1;
      end
    end
    start = 1'b0;
    check("b2b_first_done", 64'(d1), 64'(NC + 1));
    check("b2b_done_spacing", 64'(d2 - d1), 64'(NC + 2));
    check("b2b_queue_empty", 64'(exp_q.size()), 64'(0));
    exp_q.delete();

    // randomized operations
    for (int i = 0; i < 30; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ~ra;
      do_op(ra, rb, rc, ref_add(ra, rb, rc), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    // single full-width slice
    do_op32(32'h8000_0000, 32'h8000_0000, 1'b1, {1'b1, 32'h0000_0001}, "c32_dir");
    for (int i = 0; i < 5; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      do_op32(ra, rb, rc, ref_add(ra, rb, rc), $sformatf("c32_rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
